// File: rtl/dmem_responder_pkg.sv
// Shared constants, FSM state encoding and helpers for the data-memory responder.
package dmem_responder_pkg;

    // Default widths shared with the core top.
    localparam int DMEM_ADDR_W = 16;
    localparam int DMEM_DATA_W = 32;

    // Responder FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Wait counter must hold WAIT_STATES; never narrower than one bit.
    function automatic int cnt_width(input int ws);
        return (ws < 1) ? 1 : $clog2(ws + 1);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the core load/store path and the responder.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The sender holds valid and its payload stable until that
// edge; the receiver may raise or lower ready at any time. Requests flow
// master -> slave (req_*), responses flow slave -> master (rsp_*).
interface dmem_responder_if
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    // Core side.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Responder side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder_bank.sv
// Single-port synchronous storage with per-byte write enables.
// Read is read-before-write; rdata only changes on an enabled cycle, so it
// holds the last read word for as long as the responder needs it.
module dmem_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   rdata
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-masked write and registered read on enabled cycles.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < NB; i++) begin
                    if (be[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts
// WAIT_STATES wait cycles, commits to storage on the edge entering RESP and
// holds the response until the core takes it.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = DMEM_ADDR_W,
    parameter int DATA_W      = DMEM_DATA_W,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_responder_if.slave       bus,
    output logic                  busy,
    output state_t                dbg_state
);
    localparam int NB      = DATA_W / 8;
    localparam int CNT_W   = cnt_width(WAIT_STATES);
    localparam int BANK_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;

    // Request fields captured at acceptance.
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [NB-1:0]       lat_be;

    // Registered response state.
    logic                valid_q;
    logic                err_q;
    logic                load_q;

    // Command seen by storage on the commit edge.
    logic                cmd_we;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic [NB-1:0]       cmd_be;
    logic                in_range;
    logic                commit;
    logic [DATA_W-1:0]   bank_rdata;

    // With zero wait states the commit happens on the acceptance edge, so the
    // live request is used in IDLE and the latched copy otherwise.
    always_comb begin
        cmd_we    = lat_we;
        cmd_addr  = lat_addr;
        cmd_wdata = lat_wdata;
        cmd_be    = lat_be;
        if (state == ST_IDLE) begin
            cmd_we    = bus.req_we;
            cmd_addr  = bus.req_addr;
            cmd_wdata = bus.req_wdata;
            cmd_be    = bus.req_be;
        end
        in_range = ({1'b0, cmd_addr} < DEPTH_L);
        commit   = 1'b0;
        if (!rst) begin
            if (state == ST_IDLE && bus.req_valid && WAIT_STATES == 0) begin
                commit = 1'b1;
            end else if (state == ST_WAIT && cnt == CNT_ONE) begin
                commit = 1'b1;
            end
        end
    end

    dmem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (BANK_AW)
    ) u_bank (
        .clk   (clk),
        .en    (commit && in_range),
        .we    (cmd_we),
        .addr  (cmd_addr[BANK_AW-1:0]),
        .wdata (cmd_wdata),
        .be    (cmd_be),
        .rdata (bank_rdata)
    );

    // Handshake FSM, wait counter, request latch and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        lat_we    <= bus.req_we;
                        lat_addr  <= bus.req_addr;
                        lat_wdata <= bus.req_wdata;
                        lat_be    <= bus.req_be;
                        cnt       <= CNT_INIT;
                        state     <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state   <= ST_IDLE;
                        valid_q <= 1'b0;
                        err_q   <= 1'b0;
                        load_q  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Response is formed on the same edge that commits to storage.
            if (commit) begin
                valid_q <= 1'b1;
                err_q   <= !in_range;
                load_q  <= in_range && !cmd_we;
            end
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_rdata = load_q ? bank_rdata : '0;
    assign busy          = (state != ST_IDLE);
    assign dbg_state     = state;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the processor data port: serves the word-addressed load/store requests the core issues on its 16-bit address bus.
- Accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states.
- Returns read data or a write acknowledgement over a valid/ready response channel.
- Sits between the core's load/store path and on-chip data storage; it is the reader/writer target for the address the core drives.

Parameters:
- ADDR_W, 16, request address width (word address).
- DATA_W, 32, data word width; must be a multiple of 8.
- DEPTH, 1024, number of storage words; must be ≤ 2**ADDR_W.
- WAIT_STATES, 2, cycles spent in WAIT between acceptance and response; 0 is legal.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- req_be  in  DATA_W/8  store byte enables; bit i covers byte i.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
- rsp_err  out  1  address out of range (req_addr ≥ DEPTH).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst). All state updates on the rising edge of clk.
- State machine: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch we/addr/wdata/be and set wait counter to WAIT_STATES.
  - Go to WAIT if WAIT_STATES > 0, else directly to RESP.
- WAIT:
  - Counter decrements each cycle; req_ready = 0.
  - Go to RESP on the cycle the counter reaches 1→0, i.e. exactly WAIT_STATES cycles in WAIT.
- Entering RESP (single commit edge):
  - In-range store: write the bytes selected by be; other bytes unchanged. rsp_rdata = 0, rsp_err = 0.
  - In-range load: rsp_rdata = mem[addr], rsp_err = 0.
  - Out-of-range access: no write, rsp_rdata = 0, rsp_err = 1.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err held stable until the response is accepted.
  - When rsp_ready = 1, go to IDLE.
- Latency: from the acceptance edge to rsp_valid high is WAIT_STATES+1 cycles.
- Throughput: minimum one request per WAIT_STATES+2 cycles. req_ready is never high in RESP, so there is no same-cycle turnaround.
- Ordering: a load issued after a store to the same address returns the stored data, because commit happens before the next acceptance.
- Byte enables: req_be = 0 on a store produces an ack with no change to memory.
- Stability: req_* changing after acceptance has no effect, since all request fields are latched at acceptance.
- Reset values: state IDLE, req_ready 1 from the first cycle after reset, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0, wait counter 0.
- Reset mid-operation: rst in WAIT cancels the transaction and no write occurs. rst in RESP drops rsp_valid. Storage contents are not affected by rst and are undefined at power-up.
- rst has priority over every handshake in the same cycle.
- The wait counter is $clog2(WAIT_STATES+1) bits wide, minimum 1.

Decomposition:
- Shared package holds:
  - State encoding typedef: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - Default DATA_W/ADDR_W constants shared with the core top.
- Sub-module dmem_bank:
  - Single-port synchronous storage array (DEPTH × DATA_W) with per-byte write enable.
  - Isolates the memory so it can be mapped to block RAM.
  - The FSM and handshake stay in dmem_responder.

Test Plan:
- Reset then idle: hold rst 3 cycles → req_ready=1, rsp_valid=0, busy=0, rsp_rdata=0 on the first cycle after release.
- Store then load with WAIT_STATES=2:
  - Store addr 0x0010, data 0xDEADBEEF, be 4'hF → rsp_valid rises exactly 3 cycles after acceptance with rsp_err=0 and rsp_rdata=0.
  - Load addr 0x0010 → rsp_rdata=0xDEADBEEF.
- Partial store: store 0x11223344 with be 4'b0101 to a word holding 0xDEADBEEF, then load → 0xDE22BE44.
- Out of range (DEPTH=1024): load addr 0x0400 → rsp_err=1, rsp_rdata=0. Store to 0x0400 changes no word; a load of addr 0x0000 is unchanged.
- Response backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stable and req_ready=0 throughout; drop to IDLE the cycle after rsp_ready=1.
- Reset mid-WAIT and zero-wait:
  - Store 0xCAFEF00D to addr 0x0020, assert rst during WAIT → no write; a later load returns the prior value.
  - With WAIT_STATES=0, rsp_valid rises 1 cycle after acceptance.
